// File: rtl/ram_ws_rs_data_nway.sv
// -----------------------------------------------------------------------------
// ram_ws_rs_data_nway
// N-way icache data RAM with one write port and one read port.
// - Byte-enabled writes.
// - Same-cycle write-to-read bypass (write-first on collision).
// - Optional output register; o_rvalid marks valid o_rdata.
// - Post-reset init sweep that zeroes every entry of every way.
//
// Ports
//   i_clk        single clock, rising edge
//   i_rst        synchronous active-high reset
//   i_rreq       read request
//   i_rway       read way select
//   i_raddr      read set index
//   i_wreq       write request
//   i_wway       write way select
//   i_waddr      write set index
//   i_wdata      write data
//   i_be         byte enables; bit i covers i_wdata[8i+7:8i]
//   o_rdata      read data; valid while o_rvalid is high, held otherwise
//   o_rvalid     one-cycle read-valid strobe
//   o_init_busy  high while the clear sweep runs
// -----------------------------------------------------------------------------
module ram_ws_rs_data_nway #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_WAYS   = 4,
    parameter int OUT_REG    = 1,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rreq,
    input  logic [WAY_W-1:0]      i_rway,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic                  i_wreq,
    input  logic [WAY_W-1:0]      i_wway,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BE_WIDTH-1:0]   i_be,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_init_busy
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  w_init_busy;
    logic                  w_run;

    logic [DATA_WIDTH-1:0] w_way_rdata [NUM_WAYS];
    logic [DATA_WIDTH-1:0] w_rd_raw;
    logic [DATA_WIDTH-1:0] w_rd_merged;
    logic                  w_rway_ok;
    logic                  w_way_hit;
    logic                  w_coll;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;

    // ------------------------------------------------------------------
    // Init FSM
    // ------------------------------------------------------------------

    // State register: reset always restarts the sweep.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave INIT once the last entry has been cleared.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_INIT;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    // Output decode of the FSM.
    always_comb begin
        w_init_busy = 1'b1;
        case (r_state)
            ST_INIT: w_init_busy = 1'b1;
            ST_RUN:  w_init_busy = 1'b0;
            default: w_init_busy = 1'b1;
        endcase
    end

    assign w_run       = ~w_init_busy;
    assign o_init_busy = w_init_busy;

    // Sweep pointer: advances once per INIT cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_init_cnt <= {ADDR_WIDTH{1'b0}};
        end else if (w_init_busy) begin
            r_init_cnt <= r_init_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Storage: one array per way. Ways beyond NUM_WAYS never match a
    // select, so out-of-range writes are dropped and reads give zero.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic                  w_wr_en;

        assign w_wr_en = w_run & i_wreq & (i_wway == WAY_W'(g));

        // Array update: sweep clear in INIT, byte-masked write in RUN.
        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                if (w_init_busy) begin
                    r_mem[r_init_cnt] <= {DATA_WIDTH{1'b0}};
                end else if (w_wr_en) begin
                    for (int b = 0; b < BE_WIDTH; b++) begin
                        if (i_be[b]) begin
                            r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end

        assign w_way_rdata[g] = r_mem[i_raddr];
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Way select as an AND-OR mux; no hit means an out-of-range way.
    always_comb begin
        w_rd_raw  = {DATA_WIDTH{1'b0}};
        w_rway_ok = 1'b0;
        w_way_hit = 1'b0;
        for (int g = 0; g < NUM_WAYS; g++) begin
            w_way_hit = (i_rway == WAY_W'(g));
            w_rd_raw  = w_rd_raw | (w_way_rdata[g] & {DATA_WIDTH{w_way_hit}});
            w_rway_ok = w_rway_ok | w_way_hit;
        end
    end

    // Write-first bypass: enabled bytes of a colliding write replace the
    // old contents; disabled bytes keep what the array holds.
    always_comb begin
        w_coll      = i_wreq & w_rway_ok & (i_wway == i_rway) & (i_waddr == i_raddr);
        w_rd_merged = {DATA_WIDTH{1'b0}};
        for (int b = 0; b < BE_WIDTH; b++) begin
            w_rd_merged[8*b +: 8] = (w_coll & i_be[b]) ? i_wdata[8*b +: 8]
                                                       : w_rd_raw[8*b +: 8];
        end
    end

    // Stage 1: capture read result; data only moves on a served request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_s1_valid <= w_run & i_rreq;
            if (w_run & i_rreq) begin
                r_s1_data <= w_rd_merged;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic                  r_s2_valid;
        logic [DATA_WIDTH-1:0] r_s2_data;

        // Stage 2: optional output register, holds data between strobes.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= {DATA_WIDTH{1'b0}};
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign o_rvalid = r_s2_valid;
        assign o_rdata  = r_s2_data;
    end else begin : g_noreg
        assign o_rvalid = r_s1_valid;
        assign o_rdata  = r_s1_data;
    end

endmodule
